// File: rtl/muldiv_pkg.sv
// Shared op codes and FSM encoding for the multi-cycle multiply/divide unit.
// Also used by the controller that drives md_Op.
package muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Ops 0..3 occupy the unit for several cycles
  function automatic logic md_is_arith(logic [2:0] op);
    return !op[2];
  endfunction

endpackage

// File: rtl/muldiv_compute.sv
// Combinational 64-bit {hi,lo} result for MULT/MULTU/DIV/DIVU,
// including divide-by-zero and signed-overflow results.
module muldiv_compute
  import muldiv_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res
);

  logic               dz;
  logic               ovf;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] sa;
  logic signed [31:0] sb;
  logic [31:0]        ub;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic [31:0]        q_u;
  logic [31:0]        r_u;

  assign dz  = (b == 32'h0);
  assign ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'h0, a} * {32'h0, b};

  // Special cases get a harmless divisor; their result is muxed away
  assign sa  = a;
  assign sb  = (dz || ovf) ? 32'sd1 : b;
  assign ub  = dz ? 32'd1 : b;
  assign q_s = sa / sb;
  assign r_s = sa % sb;
  assign q_u = a / ub;
  assign r_u = a % ub;

  always_comb begin
    res = '0;
    case (op)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV: begin
        if (dz)       res = {a, 32'hFFFF_FFFF};
        else if (ovf) res = {32'h0, 32'h8000_0000};
        else          res = {r_s, q_s};
      end
      MD_DIVU: begin
        if (dz) res = {a, 32'hFFFF_FFFF};
        else    res = {r_u, q_u};
      end
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle mult/div unit with HI/LO registers and MTHI/MTLO.
// Optional `MD_CANCEL_EN adds md_Cancel to abort an op in flight.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        md_Clk,
  input  logic        md_Rst_n,
  input  logic        md_Start,
`ifdef MD_CANCEL_EN
  input  logic        md_Cancel,
`endif
  input  logic [2:0]  md_Op,
  input  logic [31:0] md_Data1,
  input  logic [31:0] md_Data2,
  output logic        md_Busy,
  output logic        md_Done,
  output logic [31:0] md_Hi,
  output logic [31:0] md_Lo
);

  localparam logic [7:0] MULT_N = 8'(MULT_CYCLES);
  localparam logic [7:0] DIV_N  = 8'(DIV_CYCLES);

  md_state_e   state;
  md_state_e   state_n;
  logic [7:0]  cnt;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic [63:0] comp_res;
  logic        cancel;
  logic        accept;
  logic        commit;
  logic        mt_hi;
  logic        mt_lo;

`ifdef MD_CANCEL_EN
  assign cancel = md_Cancel;
`else
  assign cancel = 1'b0;
`endif

  muldiv_compute u_compute (
    .op  (md_Op),
    .a   (md_Data1),
    .b   (md_Data2),
    .res (comp_res)
  );

  always_ff @(posedge md_Clk or negedge md_Rst_n) begin
    if (!md_Rst_n) state <= MD_IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    commit  = 1'b0;
    mt_hi   = 1'b0;
    mt_lo   = 1'b0;
    unique case (state)
      MD_IDLE: begin
        if (md_Start && !cancel) begin
          accept = md_is_arith(md_Op);
          mt_hi  = (md_Op == MD_MTHI);
          mt_lo  = (md_Op == MD_MTLO);
          if (accept) state_n = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (cancel) begin
          state_n = MD_IDLE;
        end else if (cnt == 8'd1) begin
          commit  = 1'b1;
          state_n = MD_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge md_Clk or negedge md_Rst_n) begin
    if (!md_Rst_n) begin
      cnt     <= '0;
      res_hi  <= '0;
      res_lo  <= '0;
      md_Hi   <= '0;
      md_Lo   <= '0;
      md_Done <= 1'b0;
    end else begin
      md_Done <= commit;
      if (accept) begin
        cnt    <= md_Op[1] ? DIV_N : MULT_N;
        res_hi <= comp_res[63:32];
        res_lo <= comp_res[31:0];
      end else if (state == MD_BUSY) begin
        cnt <= cancel ? 8'd0 : cnt - 8'd1;
      end
      if (commit) begin
        md_Hi <= res_hi;
        md_Lo <= res_lo;
      end
      if (mt_hi) md_Hi <= md_Data1;
      if (mt_lo) md_Lo <= md_Data1;
    end
  end

  assign md_Busy = (state == MD_BUSY);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, corner
// sequences and random ops against a 64-bit arithmetic model.
module tb_muldiv_unit;

  localparam int MN = 5;
  localparam int DN = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] d1 = '0;
  logic [31:0] d2 = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  muldiv_unit #(.MULT_CYCLES(MN), .DIV_CYCLES(DN)) dut (
    .md_Clk   (clk),
    .md_Rst_n (rst_n),
    .md_Start (start),
`ifdef MD_CANCEL_EN
    .md_Cancel(cancel),
`endif
    .md_Op    (op),
    .md_Data1 (d1),
    .md_Data2 (d2),
    .md_Busy  (busy),
    .md_Done  (done),
    .md_Hi    (hi),
    .md_Lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference from plain 64-bit arithmetic
  function automatic logic [63:0] ref_md(logic [2:0] o, logic [31:0] a,
                                         logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (o)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 10));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; returns #1 after the accepting edge
  task automatic issue(logic [2:0] o, logic [31:0] a, logic [31:0] b);
    start = 1'b1;
    op = o;
    d1 = a;
    d2 = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    d1 = $urandom;
    d2 = $urandom;
  endtask

  // Checks N busy cycles then the done cycle; ends at its negedge
  task automatic wait_done(int n, logic [31:0] eh, logic [31:0] el,
                           string nm);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      chk({nm, "_busy"}, 32'(busy), 32'd1);
      chk({nm, "_nodone"}, 32'(done), 32'd0);
      chk({nm, "_hold_hi"}, hi, mhi);
      chk({nm, "_hold_lo"}, lo, mlo);
    end
    @(negedge clk);
    chk({nm, "_idle"}, 32'(busy), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_hi"}, hi, eh);
    chk({nm, "_lo"}, lo, el);
    mhi = eh;
    mlo = el;
  endtask

  task automatic mt_write(logic [2:0] o, logic [31:0] v, string nm);
    start = 1'b1;
    op = o;
    d1 = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (o == 3'd4) mhi = v;
    if (o == 3'd5) mlo = v;
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_hi"}, hi, mhi);
    chk({nm, "_lo"}, lo, mlo);
    @(negedge clk);
  endtask

  vec_t vt[7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] r;
    logic [2:0]  o;
    logic [31:0] a, b;

    vt[0] = '{3'd0, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vt[1] = '{3'd2, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vt[2] = '{3'd3, 32'h5, 32'h0, 32'h5, 32'hFFFF_FFFF};
    vt[3] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000};
    vt[4] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1};
    vt[5] = '{3'd2, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD};
    vt[6] = '{3'd2, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF};

    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table, issued back-to-back
    for (int i = 0; i < 7; i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b);
      wait_done(vt[i].op[1] ? DN : MN, vt[i].hi, vt[i].lo,
                $sformatf("vec%0d", i));
    end
    @(negedge clk);
    chk("done_once", 32'(done), 32'd0);

    // MTHI held during BUSY is ignored
    issue(3'd1, 32'h0001_0000, 32'h0003_0000);
    start = 1'b1;
    op = 3'd4;
    d1 = 32'h1234_5678;
    wait_done(MN, 32'h3, 32'h0, "mthi_busy");
    start = 1'b0;
    @(negedge clk);
    chk("mthi_busy_after", hi, 32'h3);

    mt_write(3'd5, 32'hCAFE_0000, "mtlo");
    mt_write(3'd4, 32'hBEEF_0001, "mthi");
    mt_write(3'd6, 32'h5555_5555, "op6");
    mt_write(3'd7, 32'hAAAA_AAAA, "op7");

    // Reset in the 3rd busy cycle
    issue(3'd1, 32'h7, 32'h9);
    d1 = '0;
    d2 = '0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mhi = '0;
    mlo = '0;
    repeat (4) @(negedge clk);
    chk("arst_idle", 32'(busy), 32'd0);
    chk("arst_nocommit_hi", hi, 32'h0);
    chk("arst_nocommit_lo", lo, 32'h0);
    issue(3'd1, 32'h3, 32'h4);
    wait_done(MN, 32'h0, 32'd12, "post_rst");

`ifdef MD_CANCEL_EN
    issue(3'd3, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    chk("cancel_idle", 32'(busy), 32'd0);
    chk("cancel_nodone", 32'(done), 32'd0);
    chk("cancel_hi", hi, mhi);
    chk("cancel_lo", lo, mlo);
    @(negedge clk);
    chk("cancel_nodone2", 32'(done), 32'd0);
    start = 1'b1;
    op = 3'd4;
    d1 = 32'hDEAD_0000;
    cancel = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cancel = 1'b0;
    chk("cancel_mthi", hi, mhi);
    @(negedge clk);
    issue(3'd1, 32'h3, 32'h4);
    wait_done(MN, 32'h0, 32'd12, "cancel_next");
`endif

    // Random ops against the model
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 5));
      a = pick();
      b = pick();
      if (o >= 3'd4) begin
        mt_write(o, a, $sformatf("rnd%0d_mt", i));
      end else begin
        r = ref_md(o, a, b);
        issue(o, a, b);
        wait_done(o[1] ? DN : MN, r[63:32], r[31:0],
                  $sformatf("rnd%0d", i));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
